imu_spi_responder: RTL and testbench
====================================

Name: imu_spi_responder

Overview:
Synthesizable IMU emulator. It is the SPI slave (mode 0) and data-ready source that imu_controller talks to. It periodically latches a 16-bit sample, raises data_ready, and serves register reads and writes over SPI, including auto-increment bursts. It is used in hardware-in-the-loop builds and as the bench-side counterpart of imu_controller.

Parameters:
DR_PERIOD, 1024, number of clk cycles between sample ticks (must be ≥ 2)
WHO_AM_I, 8'h6A, constant returned at address 0x0F
CLK_FREQ_MHZ, 125, informational only; no logic depends on it

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-low
en  input  1  global enable for sample generation
sample  input  16  value captured into OUT_H:OUT_L on each tick
sclk  input  1  SPI clock from master, asynchronous
cs_n  input  1  SPI chip select, active-low, asynchronous
mosi  input  1  SPI master-out data, asynchronous
miso  output  1  SPI slave-out data; 0 whenever not selected
data_ready  output  1  high while an unread sample is pending

Behaviour:
- Reset (rst=0 sampled on a clk edge): miso=0, data_ready=0, CTRL=0x00, OVR=0, OUT=0x0000, tick counter=0, FSM=WAIT_DESEL.
- Input sync: sclk, cs_n and mosi each pass through a 2-FF synchronizer, followed by edge detect. SPI events are seen 3 clk after the pin edge.
- Master constraint: sclk high/low time must be ≥ 4 clk.
- SPI mode 0: mosi sampled on sclk rise; miso updated on sclk fall.
- Frame format: command byte {RW, ADDR[6:0]}, RW=1 means read. One or more data bytes follow. All bytes are MSB first.
- Register map:
  - 0x0F WHO_AM_I: read-only.
  - 0x10 CTRL: read/write; bit0 = DR_EN, bits 7:1 read back as written.
  - 0x1E STATUS: read-only; bit0 = data_ready, bit1 = OVR.
  - 0x28 OUT_L: read-only.
  - 0x29 OUT_H: read-only.
  - Any other address reads 0x00.
  - Writes to read-only or unmapped addresses are ignored.
- FSM states:
  - WAIT_DESEL: entered from reset. Goes to IDLE on cs_n high.
  - IDLE: goes to CMD on cs_n fall.
  - CMD: shifts 8 bits. On the 8th rise, latches RW and ADDR and goes to DATA. For a read, loads the shift register from ADDR, and bit7 appears on miso at the next sclk fall.
  - DATA: handles bytes of 8 bits each.
    - On the 8th rise of a write byte, the register is written in the same clk cycle.
    - On the 8th rise of any byte, ADDR increments by 1 (7-bit wrap from 0x7F to 0x00).
    - For a read, the next byte is preloaded and its MSB is driven at the following fall.
- cs_n rise in any state: go to IDLE and drive miso to 0. A partial byte is discarded; no write occurs.
- Reset while cs_n is low: the rest of that frame is ignored (WAIT_DESEL).
- Tick generation:
  - Counter runs only while en && DR_EN; otherwise it is held at 0.
  - A tick occurs when count reaches DR_PERIOD-1; the counter then wraps to 0.
  - On tick: OUT ← sample and data_ready ← 1. If data_ready was already 1, OVR ← 1.
- Coherence: a tick while cs_n is low is deferred. The capture and flag update happen on the first clk cycle after cs_n rises. A second tick during the same frame counts as overrun.
- data_ready clears on completion of a read byte at address 0x29.
- OVR clears on completion of a read byte at address 0x1E.
- Same-cycle set and clear: set wins.
- No handshake with en: clearing en or DR_EN mid-period discards the partial count. data_ready and OVR keep their values.

Decomposition:
- Package imu_spi_pkg holds:
  - register address constants (ADDR_WHO_AM_I, ADDR_CTRL, ADDR_STATUS, ADDR_OUT_L, ADDR_OUT_H);
  - the FSM state enum (WAIT_DESEL, IDLE, CMD, DATA);
  - the RW bit position.
- One sub-module, spi_sync_edge: 2-FF synchronizer plus rise/fall pulse generation. It is instantiated per async input (rise/fall pulses are used for sclk and cs_n only).
- Register file, FSM and tick counter stay in the top module.

Test Plan:
- Reset, then an SPI read with command 0x8F and one data byte -> miso returns 0x6A. data_ready stays 0.
- Write 0x10 ← 0x01 with en=1, sample=16'hBEEF, DR_PERIOD=64 -> data_ready rises 64 clk after the write completes. A burst read from 0xA8 (2 bytes) returns 0xEF then 0xBE. data_ready falls 3 clk after the last sclk rise.
- Let two ticks pass without reading -> read 0x9E returns 0x03. A second read of 0x9E returns 0x01. After an OUT_H read, STATUS reads 0x00.
- Tick lands mid-burst with sample changed from 16'h1234 to 16'h5678 -> the burst returns 0x34, 0x12. A burst after cs_n rise returns 0x78, 0x56.
- Raise cs_n after 5 bits of a write to 0x10 -> CTRL is unchanged and miso=0. Writes to 0x0F are ignored (it still reads 0x6A). A burst read from 0xFF wraps: 1st data byte from address 0x7F (0x00), 2nd from address 0x00 (0x00).
- Pull rst low during a read frame and release while cs_n is still low -> no miso activity until cs_n rises. The next frame works normally and CTRL reads 0x00.

Source files
------------

// File: rtl/imu_spi_pkg.sv
// Shared definitions for the IMU SPI responder: register map, frame layout,
// FSM state encoding and the register read mux.
package imu_spi_pkg;

    localparam logic [6:0] ADDR_WHO_AM_I = 7'h0F;
    localparam logic [6:0] ADDR_CTRL     = 7'h10;
    localparam logic [6:0] ADDR_STATUS   = 7'h1E;
    localparam logic [6:0] ADDR_OUT_L    = 7'h28;
    localparam logic [6:0] ADDR_OUT_H    = 7'h29;

    // Bit of the command byte that selects a read (1) or a write (0).
    localparam int RW_BIT = 7;

    // CTRL bit that enables sample tick generation.
    localparam int CTRL_DR_EN_BIT = 0;

    typedef enum logic [1:0] {
        WAIT_DESEL,
        IDLE,
        CMD,
        DATA
    } spi_state_e;

    // Register read mux; unmapped addresses return zero.
    function automatic logic [7:0] reg_read(
        input logic [6:0]  addr,
        input logic [7:0]  who_am_i,
        input logic [7:0]  ctrl,
        input logic [7:0]  status,
        input logic [15:0] out_val
    );
        logic [7:0] data;
        data = 8'h00;
        case (addr)
            ADDR_WHO_AM_I: data = who_am_i;
            ADDR_CTRL:     data = ctrl;
            ADDR_STATUS:   data = status;
            ADDR_OUT_L:    data = out_val[7:0];
            ADDR_OUT_H:    data = out_val[15:8];
            default:       data = 8'h00;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous SPI pin, followed by a third
// flop that turns level changes into single-cycle rise/fall pulses.
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronizer chain plus one delayed copy for edge detection.
    // NOTE: flops are written with <= so every stage samples the value from
    // before this edge; blocking = here would collapse the chain to one flop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/imu_spi_responder.sv
// IMU emulator: SPI mode-0 slave with a small register map, plus a periodic
// sample tick that latches an external 16-bit value and raises data_ready.
module imu_spi_responder
    import imu_spi_pkg::*;
#(
    parameter int unsigned DR_PERIOD    = 1024,
    parameter logic [7:0]  WHO_AM_I     = 8'h6A,
    parameter int unsigned CLK_FREQ_MHZ = 125
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] sample,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        data_ready
);

    localparam int CNT_W = (DR_PERIOD > 2) ? $clog2(DR_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DR_PERIOD - 1);

    // Synchronized pins and edge pulses.
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_sync_edge u_sync_sclk (
        .clk    (clk),
        .rst    (rst),
        .async_i(sclk),
        .sync_o (sclk_lvl),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_sync_edge u_sync_cs (
        .clk    (clk),
        .rst    (rst),
        .async_i(cs_n),
        .sync_o (cs_lvl),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    spi_sync_edge u_sync_mosi (
        .clk    (clk),
        .rst    (rst),
        .async_i(mosi),
        .sync_o (mosi_lvl),
        .rise_o (mosi_rise),
        .fall_o (mosi_fall)
    );

    // Outputs of the synchronizers that have no load, and the informational
    // clock frequency parameter.
    logic unused_ok;
    assign unused_ok = ^{sclk_lvl, mosi_rise, mosi_fall, CLK_FREQ_MHZ};

    // SPI frame state.
    spi_state_e  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  tx_q, tx_d;
    logic [6:0]  addr_q, addr_d;
    logic        rw_q, rw_d;
    logic        miso_q, miso_d;

    // Register file, tick counter and deferred-tick bookkeeping.
    logic [7:0]       ctrl_q, ctrl_d;
    logic [15:0]      out_q, out_d;
    logic             dr_q, dr_d;
    logic             ovr_q, ovr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             pend_ovr_q, pend_ovr_d;

    // Strobes from the SPI engine into the register file.
    logic       wr_ctrl;
    logic       clr_dr;
    logic       clr_ovr;
    logic [7:0] rx_shift;
    logic [6:0] next_addr;
    logic [7:0] status;

    assign rx_shift  = {rx_q[6:0], mosi_lvl};
    assign next_addr = addr_q + 7'd1;
    assign status    = {6'b0, ovr_q, dr_q};

    // SPI engine: frame FSM, bit counting, shift registers and miso drive.
    // NOTE: every output is given its hold value first, so no path through
    // the case statement leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        miso_d    = miso_q;
        wr_ctrl   = 1'b0;
        clr_dr    = 1'b0;
        clr_ovr   = 1'b0;

        if (cs_rise) begin
            // Deselect aborts any frame; a partial byte is simply dropped.
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            miso_d    = 1'b0;
        end else begin
            case (state_q)
                WAIT_DESEL: begin
                    if (cs_lvl) state_d = IDLE;
                end
                IDLE: begin
                    if (cs_fall) begin
                        state_d   = CMD;
                        bit_cnt_d = 3'd0;
                        miso_d    = 1'b0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        rx_d      = rx_shift;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rw_d    = rx_shift[RW_BIT];
                            addr_d  = rx_shift[6:0];
                            tx_d    = reg_read(rx_shift[6:0], WHO_AM_I, ctrl_q, status, out_q);
                            state_d = DATA;
                        end
                    end
                end
                DATA: begin
                    if (sclk_rise) begin
                        rx_d      = rx_shift;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            addr_d = next_addr;
                            if (rw_q) begin
                                tx_d    = reg_read(next_addr, WHO_AM_I, ctrl_q, status, out_q);
                                clr_dr  = (addr_q == ADDR_OUT_H);
                                clr_ovr = (addr_q == ADDR_STATUS);
                            end else begin
                                wr_ctrl = (addr_q == ADDR_CTRL);
                            end
                        end
                    end else if (sclk_fall && rw_q) begin
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                end
                default: state_d = WAIT_DESEL;
            endcase
        end
    end

    // Tick counter, deferred capture while selected, flags and CTRL writes.
    logic run, tick, apply, direct;

    always_comb begin
        run    = en && ctrl_q[CTRL_DR_EN_BIT];
        tick   = run && (cnt_q == CNT_LAST);
        apply  = pend_q && cs_lvl;
        direct = tick && cs_lvl;

        cnt_d      = (!run || tick) ? '0 : cnt_q + CNT_W'(1);
        ctrl_d     = wr_ctrl ? rx_shift : ctrl_q;
        out_d      = out_q;
        dr_d       = dr_q;
        ovr_d      = ovr_q;
        pend_d     = pend_q;
        pend_ovr_d = pend_ovr_q;

        // A tick during a frame is held back so OUT stays coherent.
        if (tick && !cs_lvl) begin
            pend_d     = 1'b1;
            pend_ovr_d = pend_ovr_q | pend_q;
        end
        if (apply) begin
            pend_d     = 1'b0;
            pend_ovr_d = 1'b0;
        end

        if (clr_dr)  dr_d  = 1'b0;
        if (clr_ovr) ovr_d = 1'b0;

        // Set after clear so a simultaneous set wins.
        if (apply || direct) begin
            out_d = sample;
            dr_d  = 1'b1;
            if (dr_q || (apply && (pend_ovr_q || direct))) ovr_d = 1'b1;
        end
    end

    // SPI engine state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= WAIT_DESEL;
            bit_cnt_q <= 3'd0;
            rx_q      <= 8'h00;
            tx_q      <= 8'h00;
            addr_q    <= 7'h00;
            rw_q      <= 1'b0;
            miso_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            miso_q    <= miso_d;
        end
    end

    // Register file and tick state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_q     <= 8'h00;
            out_q      <= 16'h0000;
            dr_q       <= 1'b0;
            ovr_q      <= 1'b0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            pend_ovr_q <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            out_q      <= out_d;
            dr_q       <= dr_d;
            ovr_q      <= ovr_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_ovr_q <= pend_ovr_d;
        end
    end

    assign miso       = miso_q;
    assign data_ready = dr_q;

endmodule

// File: tb/tb_imu_spi_responder.sv
// Self-checking bench for imu_spi_responder: drives SPI mode-0 frames with
// 4-clk sclk half periods, queues expected read bytes before each frame and
// compares them against the bytes captured from miso.
`timescale 1ns/1ps
module tb_imu_spi_responder;

    localparam int DR_PERIOD = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [15:0] sample = 16'h0000;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic        data_ready;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    logic dr_at2, dr_at3;
    logic miso_any;
    logic [7:0] tx_bytes [8];
    logic [7:0] exp_q [$];
    logic [7:0] rx_q [$];
    logic [7:0] exp_b, got_b;

    imu_spi_responder #(
        .DR_PERIOD   (DR_PERIOD),
        .WHO_AM_I    (8'h6A),
        .CLK_FREQ_MHZ(125)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sample    (sample),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .data_ready(data_ready)
    );

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // One SPI bit: mosi set while sclk low, miso sampled at the rising edge.
    task automatic spi_bit(input logic b, output logic m);
        mosi = b;
        repeat (4) begin
            @(negedge clk);
            miso_any = miso_any | miso;
        end
        m = miso;
        sclk = 1'b1;
        last_rise_cyc = cyc;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            miso_any = miso_any | miso;
            if (k == 2) dr_at2 = data_ready;
            if (k == 3) dr_at3 = data_ready;
        end
        sclk = 1'b0;
    endtask

    // Full frame of nbytes from tx_bytes, then extra_bits bits of the next
    // entry before deselect. Bytes after a read command go to rx_q.
    task automatic spi_frame(input int nbytes, input int extra_bits);
        logic [7:0] r;
        logic m;
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int b = 0; b < nbytes; b++) begin
            r = 8'h00;
            for (int i = 7; i >= 0; i--) begin
                spi_bit(tx_bytes[b][i], m);
                r = {r[6:0], m};
            end
            if (b > 0 && tx_bytes[0][7]) rx_q.push_back(r);
        end
        for (int i = 0; i < extra_bits; i++) spi_bit(tx_bytes[nbytes][7-i], m);
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_read(input logic [7:0] cmd, input int n);
        tx_bytes[0] = cmd;
        for (int i = 1; i < 8; i++) tx_bytes[i] = 8'h00;
        spi_frame(n + 1, 0);
    endtask

    task automatic spi_write(input logic [7:0] addr, input logic [7:0] data);
        tx_bytes[0] = addr;
        tx_bytes[1] = data;
        spi_frame(2, 0);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (miso !== 1'b0 || data_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_during: miso=%b data_ready=%b, both must be 0", miso, data_ready);
        end
        rst = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (miso !== 1'b0 || data_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_after: miso=%b data_ready=%b, both must be 0", miso, data_ready);
        end
    endtask

    task automatic test_who_am_i;
        exp_q.push_back(8'h6A);
        spi_read(8'h8F, 1);
        exp_q.push_back(8'h00);
        spi_read(8'h90, 1);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h6A);
        exp_q.push_back(8'h00);
        spi_read(8'h8E, 3);
        while (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            got_b = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx;
            checks++;
            if (got_b !== exp_b) begin
                errors++;
                $display("FAIL who_am_i: read %h, expected %h", got_b, exp_b);
            end
        end
        checks++;
        if (data_ready !== 1'b0) begin
            errors++;
            $display("FAIL who_am_i_dr: data_ready=%b, expected 0", data_ready);
        end
    endtask

    task automatic test_tick;
        int n;
        int t0;
        sample = 16'hBEEF;
        en = 1'b1;
        spi_write(8'h10, 8'h01);
        t0 = last_rise_cyc;
        n = 0;
        while (data_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        en = 1'b0;
        checks++;
        if (data_ready !== 1'b1 || (cyc - t0) != 67) begin
            errors++;
            $display("FAIL tick_latency: data_ready=%b after %0d clk from last sclk rise, expected 1 after 67",
                     data_ready, cyc - t0);
        end
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hBE);
        spi_read(8'hA8, 2);
        checks++;
        if (dr_at2 !== 1'b1 || dr_at3 !== 1'b0) begin
            errors++;
            $display("FAIL dr_clear_timing: data_ready +2clk=%b +3clk=%b, expected 1 then 0", dr_at2, dr_at3);
        end
        exp_q.push_back(8'h00);
        spi_read(8'h9E, 1);
        while (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            got_b = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx;
            checks++;
            if (got_b !== exp_b) begin
                errors++;
                $display("FAIL tick_burst: read %h, expected %h", got_b, exp_b);
            end
        end
    endtask

    task automatic test_overrun;
        sample = 16'hC0DE;
        en = 1'b1;
        repeat (150) @(negedge clk);
        en = 1'b0;
        checks++;
        if (data_ready !== 1'b1) begin
            errors++;
            $display("FAIL overrun_dr: data_ready=%b, expected 1", data_ready);
        end
        exp_q.push_back(8'h03);
        spi_read(8'h9E, 1);
        exp_q.push_back(8'h01);
        spi_read(8'h9E, 1);
        exp_q.push_back(8'hC0);
        spi_read(8'hA9, 1);
        exp_q.push_back(8'h00);
        spi_read(8'h9E, 1);
        while (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            got_b = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx;
            checks++;
            if (got_b !== exp_b) begin
                errors++;
                $display("FAIL overrun_status: read %h, expected %h", got_b, exp_b);
            end
        end
        checks++;
        if (data_ready !== 1'b0) begin
            errors++;
            $display("FAIL overrun_dr_clear: data_ready=%b, expected 0", data_ready);
        end
    endtask

    task automatic test_coherence;
        int n;
        sample = 16'h1234;
        en = 1'b1;
        n = 0;
        while (data_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (data_ready !== 1'b1) begin
            errors++;
            $display("FAIL coherence_tick: data_ready=%b after %0d clk, expected 1", data_ready, n);
        end
        // Ticks during this burst must not disturb OUT until deselect.
        sample = 16'h5678;
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h12);
        spi_read(8'hA8, 2);
        en = 1'b0;
        checks++;
        if (data_ready !== 1'b1) begin
            errors++;
            $display("FAIL coherence_deferred: data_ready=%b, expected 1", data_ready);
        end
        exp_q.push_back(8'h78);
        exp_q.push_back(8'h56);
        spi_read(8'hA8, 2);
        exp_q.push_back(8'h02);
        spi_read(8'h9E, 1);
        exp_q.push_back(8'h00);
        spi_read(8'h9E, 1);
        while (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            got_b = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx;
            checks++;
            if (got_b !== exp_b) begin
                errors++;
                $display("FAIL coherence_burst: read %h, expected %h", got_b, exp_b);
            end
        end
    endtask

    task automatic test_abort_and_ro;
        tx_bytes[0] = 8'h10;
        tx_bytes[1] = 8'hFE;
        miso_any = 1'b0;
        spi_frame(1, 5);
        checks++;
        if (miso_any !== 1'b0 || miso !== 1'b0) begin
            errors++;
            $display("FAIL abort_miso: miso activity=%b miso=%b, expected 0", miso_any, miso);
        end
        exp_q.push_back(8'h01);
        spi_read(8'h90, 1);
        spi_write(8'h0F, 8'h55);
        exp_q.push_back(8'h6A);
        spi_read(8'h8F, 1);
        spi_write(8'h10, 8'hA4);
        exp_q.push_back(8'hA4);
        spi_read(8'h90, 1);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        spi_read(8'hFF, 2);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h6A);
        exp_q.push_back(8'hA4);
        spi_read(8'h8E, 3);
        while (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            got_b = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx;
            checks++;
            if (got_b !== exp_b) begin
                errors++;
                $display("FAIL abort_ro_wrap: read %h, expected %h", got_b, exp_b);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        logic m;
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] cmd;
            cmd = 8'h8F;
            spi_bit(cmd[i], m);
        end
        for (int i = 0; i < 3; i++) spi_bit(1'b0, m);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        miso_any = 1'b0;
        for (int i = 0; i < 13; i++) spi_bit(1'b1, m);
        checks++;
        if (miso_any !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame_miso: miso activity=%b, expected 0", miso_any);
        end
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (8) @(negedge clk);
        exp_q.push_back(8'h00);
        spi_read(8'h90, 1);
        exp_q.push_back(8'h6A);
        spi_read(8'h8F, 1);
        while (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            got_b = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx;
            checks++;
            if (got_b !== exp_b) begin
                errors++;
                $display("FAIL reset_frame_next: read %h, expected %h", got_b, exp_b);
            end
        end
        checks++;
        if (data_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame_dr: data_ready=%b, expected 0", data_ready);
        end
    endtask

    initial begin
        miso_any = 1'b0;
        dr_at2 = 1'b0;
        dr_at3 = 1'b0;
        for (int i = 0; i < 8; i++) tx_bytes[i] = 8'h00;
        @(negedge clk);
        test_reset;
        test_who_am_i;
        test_tick;
        test_overrun;
        test_coherence;
        test_abort_and_ro;
        test_reset_mid_frame;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
